// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM unified-memory port arbiter.
// State and owner encodings plus latency-counter sizing.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_LENGTH = 2;
  localparam int MEM_LAT_MAX      = 8;
  localparam int LAT_W            = $clog2(MEM_LAT_MAX);

  typedef enum logic [ARB_STATE_LENGTH-1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IF = 1'b0,
    ARB_OWNER_DM = 1'b1
  } arb_owner_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// Loadable down-counter timing the fixed memory read latency.
// o_zero flags the cycle in which memory read data is valid.
module mem_lat_timer
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-port accesses onto one synchronous memory.
// DM has fixed priority; DONE hands straight over to a waiting other port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_err,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  arb_state_e          r_state;
  arb_state_e          w_next;
  arb_owner_e          r_owner;
  logic                r_we;
  logic [ADDR_W+1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_if_ready;
  logic                r_dm_ready;
  logic                r_if_err;
  logic                r_dm_err;

  logic w_grant_if;
  logic w_grant_dm;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;
  logic w_done_en;
  logic w_own_if;
  logic w_own_dm;
  logic w_err;
  logic w_unused;

  assign w_unused = ^{if_addr[31:ADDR_W+2], dm_addr[31:ADDR_W+2]};

  mem_lat_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LAT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_done_en  = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (dm_req) begin
          w_grant_dm = 1'b1;
          w_next     = ARB_ISSUE;
        end else if (if_req) begin
          w_grant_if = 1'b1;
          w_next     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        w_cnt_load = 1'b1;
        w_next     = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (w_cnt_zero) begin
          w_done_en = 1'b1;
          w_next    = ARB_DONE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ARB_DONE: begin
        // the finishing owner's req is still high here and is masked
        if ((r_owner == ARB_OWNER_DM) && if_req) begin
          w_grant_if = 1'b1;
          w_next     = ARB_ISSUE;
        end else if ((r_owner == ARB_OWNER_IF) && dm_req) begin
          w_grant_dm = 1'b1;
          w_next     = ARB_ISSUE;
        end else begin
          w_next = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  assign w_own_if = w_done_en && (r_owner == ARB_OWNER_IF);
  assign w_own_dm = w_done_en && (r_owner == ARB_OWNER_DM);
  assign w_err    = is_misaligned(r_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_owner <= ARB_OWNER_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_dm) begin
        r_owner <= ARB_OWNER_DM;
        r_we    <= dm_we;
        r_addr  <= dm_addr[ADDR_W+1:0];
        r_wdata <= dm_wdata;
      end else if (w_grant_if) begin
        r_owner <= ARB_OWNER_IF;
        r_we    <= 1'b0;
        r_addr  <= if_addr[ADDR_W+1:0];
        r_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_if_err   <= 1'b0;
      r_dm_err   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_ready <= w_own_if;
      r_dm_ready <= w_own_dm;
      r_if_err   <= w_own_if && w_err;
      r_dm_err   <= w_own_dm && w_err;
      if (w_own_if) begin
        r_if_rdata <= mem_rdata;
      end
      // stores leave the load data register untouched
      if (w_own_dm && !r_we) begin
        r_dm_rdata <= mem_rdata;
      end
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign if_err    = r_if_err;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ready  = r_dm_ready;
  assign dm_err    = r_dm_err;
  assign stall_if  = if_req & ~r_if_ready;
  assign stall_dm  = dm_req & ~r_dm_ready;
  assign mem_en    = (r_state == ARB_ISSUE);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr[ADDR_W+1:2];
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter at MEM_LAT=1 (A) and MEM_LAT=3 (B).
// Expected responses are queued at stimulus time and popped on each ready.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t qa_if[$];
  exp_t qa_dm[$];
  exp_t qb_dm[$];

  logic        a_if_req, a_if_ready, a_if_err;
  logic [31:0] a_if_addr, a_if_rdata;
  logic        a_dm_req, a_dm_we, a_dm_ready, a_dm_err;
  logic [31:0] a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic        a_stall_if, a_stall_dm, a_mem_en, a_mem_we;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;

  logic        b_if_req, b_if_ready, b_if_err;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_dm_req, b_dm_we, b_dm_ready, b_dm_err;
  logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic        b_stall_if, b_stall_dm, b_mem_en, b_mem_we;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  logic [31:0] mema [0:1023];
  logic [31:0] memb [0:1023];
  logic [31:0] pb0, pb1;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
    .if_ready(a_if_ready), .if_err(a_if_err),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_rdata(a_dm_rdata),
    .dm_ready(a_dm_ready), .dm_err(a_dm_err),
    .stall_if(a_stall_if), .stall_dm(a_stall_dm),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_ready(b_if_ready), .if_err(b_if_err),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_rdata(b_dm_rdata),
    .dm_ready(b_dm_ready), .dm_err(b_dm_err),
    .stall_if(b_stall_if), .stall_dm(b_stall_dm),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // memory A: 1-cycle read; garbage when not enabled
  always @(posedge clk) begin
    if (preload) begin
      mema[0] <= 32'h11111111;
      mema[1] <= 32'h22222222;
      mema[2] <= 32'h33333333;
      mema[4] <= 32'h24020005;
      mema[8] <= 32'hA5A5A5A5;
    end else if (a_mem_en && a_mem_we) begin
      mema[a_mem_addr] <= a_mem_wdata;
    end
    a_mem_rdata <= a_mem_en ? mema[a_mem_addr] : 32'hBAD0BAD0;
  end

  // memory B: 3-cycle read pipeline
  always @(posedge clk) begin
    if (preload) begin
      memb[16] <= 32'h12345678;
      memb[32] <= 32'hFFFF0000;
    end else if (b_mem_en && b_mem_we) begin
      memb[b_mem_addr] <= b_mem_wdata;
    end
    pb0         <= b_mem_en ? memb[b_mem_addr] : 32'hBAD0BAD0;
    pb1         <= pb0;
    b_mem_rdata <= pb1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_if_ready) begin
      if (qa_if.size() == 0) begin
        chk("a_if_spur", {31'd0, a_if_ready}, 32'd0);
      end else begin
        e = qa_if.pop_front();
        chk("a_if_rdata", a_if_rdata, e.data);
        chk("a_if_err", {31'd0, a_if_err}, {31'd0, e.err});
        chk("a_if_cyc", cyc, e.cyc);
      end
    end
    if (a_dm_ready) begin
      if (qa_dm.size() == 0) begin
        chk("a_dm_spur", {31'd0, a_dm_ready}, 32'd0);
      end else begin
        e = qa_dm.pop_front();
        chk("a_dm_rdata", a_dm_rdata, e.data);
        chk("a_dm_err", {31'd0, a_dm_err}, {31'd0, e.err});
        chk("a_dm_cyc", cyc, e.cyc);
      end
    end
    if (b_dm_ready) begin
      if (qb_dm.size() == 0) begin
        chk("b_dm_spur", {31'd0, b_dm_ready}, 32'd0);
      end else begin
        e = qb_dm.pop_front();
        chk("b_dm_rdata", b_dm_rdata, e.data);
        chk("b_dm_err", {31'd0, b_dm_err}, {31'd0, e.err});
        chk("b_dm_cyc", cyc, e.cyc);
      end
    end
    if (b_if_ready) chk("b_if_spur", {31'd0, b_if_ready}, 32'd0);
  end

  initial begin
    preload = 1'b1;
    {a_if_req, a_dm_req, a_dm_we, b_if_req, b_dm_req, b_dm_we} = '0;
    {a_if_addr, a_dm_addr, a_dm_wdata} = '0;
    {b_if_addr, b_dm_addr, b_dm_wdata} = '0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;

    @(negedge clk);
    chk("rst_if_ready", {31'd0, a_if_ready}, 32'd0);
    chk("rst_dm_ready", {31'd0, a_dm_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, a_mem_en}, 32'd0);
    chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_dm_rdata", a_dm_rdata, 32'd0);
    chk("rst_b_mem_en", {31'd0, b_mem_en}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single fetch
    @(posedge clk); #1;
    t0 = cyc;
    a_if_req = 1'b1; a_if_addr = 32'h10;
    qa_if.push_back('{32'h24020005, 1'b0, t0 + 3});
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("f_stall_if", {31'd0, a_stall_if}, 32'(k < 3));
      chk("f_mem_en", {31'd0, a_mem_en}, 32'(k == 1));
      if (k == 1) begin
        chk("f_mem_we", {31'd0, a_mem_we}, 32'd0);
        chk("f_mem_addr", 32'(a_mem_addr), 32'd4);
      end
    end
    @(posedge clk); #1 a_if_req = 1'b0;

    // contention: DM store first, then IF straight from DONE
    @(posedge clk); #1;
    t0 = cyc;
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h20;
    a_dm_wdata = 32'hDEADBEEF;
    a_if_req = 1'b1; a_if_addr = 32'h0;
    qa_dm.push_back('{32'h0, 1'b0, t0 + 3});
    qa_if.push_back('{32'h11111111, 1'b0, t0 + 6});
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk("c_mem_en", {31'd0, a_mem_en}, 32'(k == 1 || k == 4));
      chk("c_stall_dm", {31'd0, a_stall_dm}, 32'(k < 3));
      chk("c_stall_if", {31'd0, a_stall_if}, 32'(k < 6));
      if (k == 1) begin
        chk("c_st_we", {31'd0, a_mem_we}, 32'd1);
        chk("c_st_addr", 32'(a_mem_addr), 32'd8);
        chk("c_st_wdata", a_mem_wdata, 32'hDEADBEEF);
      end
      if (k == 4) begin
        chk("c_if_we", {31'd0, a_mem_we}, 32'd0);
        chk("c_if_addr", 32'(a_mem_addr), 32'd0);
      end
      @(posedge clk); #1;
      if (k == 3) a_dm_req = 1'b0;
      if (k == 6) a_if_req = 1'b0;
    end

    // misaligned load reads back the stored word
    t0 = cyc;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h22;
    qa_dm.push_back('{32'hDEADBEEF, 1'b1, t0 + 3});
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("ma_mem_addr", 32'(a_mem_addr), 32'd8);
        chk("ma_mem_we", {31'd0, a_mem_we}, 32'd0);
      end
      @(posedge clk); #1;
      if (k == 3) a_dm_req = 1'b0;
    end

    // if_req held throughout; exactly one grant per transaction
    t0 = cyc;
    a_if_req = 1'b1; a_if_addr = 32'h0;
    qa_if.push_back('{32'h11111111, 1'b0, t0 + 3});
    qa_if.push_back('{32'h22222222, 1'b0, t0 + 7});
    qa_if.push_back('{32'h33333333, 1'b0, t0 + 11});
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      chk("m_mem_en", {31'd0, a_mem_en}, 32'((k % 4 == 1) && k < 12));
      @(posedge clk); #1;
      if (k == 3) a_if_addr = 32'h4;
      if (k == 7) a_if_addr = 32'h8;
      if (k == 11) a_if_req = 1'b0;
    end

    // async reset during WAIT of a DM load
    t0 = cyc;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h10;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("r_dm_ready", {31'd0, a_dm_ready}, 32'd0);
    chk("r_mem_en0", {31'd0, a_mem_en}, 32'd0);
    chk("r_mem_addr0", 32'(a_mem_addr), 32'd0);
    chk("r_dm_rdata0", a_dm_rdata, 32'd0);
    chk("r_if_rdata0", a_if_rdata, 32'd0);
    chk("r_stall_dm", {31'd0, a_stall_dm}, 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    t0 = cyc;
    qa_dm.push_back('{32'h24020005, 1'b0, t0 + 3});
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("r_mem_en", {31'd0, a_mem_en}, 32'(k == 1));
      if (k == 1) chk("r_mem_addr", 32'(a_mem_addr), 32'd4);
      @(posedge clk); #1;
      if (k == 3) a_dm_req = 1'b0;
    end

    // MEM_LAT=3 load, address changed mid-transaction
    t0 = cyc;
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h40;
    qb_dm.push_back('{32'h12345678, 1'b0, t0 + 5});
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk("l3_mem_en", {31'd0, b_mem_en}, 32'(k == 1));
      chk("l3_stall_dm", {31'd0, b_stall_dm}, 32'(k < 5));
      if (k == 1) chk("l3_mem_addr", 32'(b_mem_addr), 32'd16);
      @(posedge clk); #1;
      if (k == 1) b_dm_addr = 32'h80;
      if (k == 4) b_dm_req = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("left_a_if", qa_if.size(), 32'd0);
    chk("left_a_dm", qa_dm.size(), 32'd0);
    chk("left_b_dm", qb_dm.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between two requesters: instruction fetch (IF, read-only) and the MEM-stage data port (DM, read/write).
- Sits between the IF/MEM pipeline stages and a unified memory that replaces the separate instruction and data memories.
- Sequences each access through issue, fixed-latency wait and response, returning a one-cycle ready pulse.
- Drives per-port stall signals consumed by the pipeline pause logic.

Parameters:
- ADDR_W, 10: memory word-address width. mem_addr = byte_addr[ADDR_W+1:2].
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from mem_en to mem_rdata valid. Legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  DATA_W  fetched word; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- if_err  out  1  misaligned fetch flag; valid with if_ready
- dm_req  in  1  data request; held high until dm_ready
- dm_we  in  1  1=store, 0=load
- dm_addr  in  32  data byte address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for DM
- dm_err  out  1  misaligned data flag; valid with dm_ready
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_dm  out  1  dm_req & ~dm_ready (combinational)
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async): state=IDLE, latency counter=0, latched owner/addr/wdata/we=0. Every registered output goes to 0: ready, err, rdata, mem_*.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: at each edge, sample requests.
  - dm_req=1: latch DM fields, owner=DM, go to ISSUE. DM has fixed priority over IF.
  - else if_req=1: latch IF fields, owner=IF, we=0, go to ISSUE.
  - else stay in IDLE.
- ISSUE (one cycle): mem_en=1; mem_we, mem_addr, mem_wdata driven from the latched fields. Load counter with MEM_LAT-1, go to WAIT.
- WAIT: mem_en=0. Decrement the counter each cycle. When counter==0, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to DONE.
- DONE (one cycle): owner's ready=1. err=1 if latched addr[1:0]!=0.
  - The owner's req is still high in this cycle and is ignored (masked).
  - If the other port's req=1, latch it and go directly to ISSUE; otherwise go to IDLE.
- Latency: req sampled in IDLE at cycle 0 → ISSUE cycle 1 → mem_rdata valid cycle 1+MEM_LAT → ready at cycle 2+MEM_LAT.
- Store: dm_ready is still produced after the full latency. dm_rdata is not updated and holds its previous value.
- rdata registers hold their value after ready drops.
- Misaligned access: still performed at the aligned word (addr[1:0] ignored); err flag raised with ready.
- Protocol violation (req dropped before ready): the transaction completes anyway. The ready pulse is still produced and no state is corrupted.
- Fields changing while req is held: ignored. Fields are latched only at grant.
- Both requests present in IDLE: DM is served first, then IF is issued straight from DM's DONE. No idle bubble between the two.
- Reset mid-transaction: FSM returns to IDLE immediately and no ready pulse is produced. A store already issued to memory may have completed (memory is not reset). Requests still held after reset release are re-granted through the normal IDLE path.

Decomposition:
- Add to const.vh: ARB_STATE_LENGTH and state codes ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_DONE; ARB_OWNER_IF/ARB_OWNER_DM; MEM_LAT_MAX.
- One natural sub-module, mem_lat_timer: loadable down-counter with a zero flag, width clog2(MEM_LAT_MAX).
- Grant logic and latches stay in the top block.

Test Plan:
- Fetch, MEM_LAT=1: mem word 4=0x24020005, if_req=1, if_addr=0x10 at cycle 0.
  - Expect mem_en=1, mem_we=0, mem_addr=4 at cycle 1.
  - Expect if_ready=1, if_rdata=0x24020005, if_err=0 at cycle 3 only.
  - Expect stall_if=1 for cycles 0-2.
- Contention, MEM_LAT=1: at cycle 0, dm_req store addr 0x20 data 0xDEADBEEF, and if_req addr 0x0.
  - Expect cycle 1: mem_en=1, mem_we=1, mem_addr=8, mem_wdata=0xDEADBEEF.
  - Expect dm_ready at cycle 3, then fetch ISSUE (mem_addr=0) at cycle 4 and if_ready at cycle 6.
  - Word 8 reads back 0xDEADBEEF.
- MEM_LAT=3 load: dm_req, dm_we=0, dm_addr=0x40, mem word 16=0x12345678.
  - Expect mem_en only at cycle 1 and dm_ready at cycle 5 with dm_rdata=0x12345678.
  - Expect stall_dm=1 for cycles 0-4.
- Misaligned load: dm_addr=0x22 → mem_addr=8, dm_ready with dm_err=1, dm_rdata=word 8.
- Reset mid-transaction: assert rst during WAIT of a DM load.
  - Expect all outputs 0 in the same cycle (async) and no dm_ready.
  - Release rst with dm_req still high: expect ISSUE one cycle after the first post-reset edge and a normal dm_ready.
- DONE masking: if_req held high continuously, address changed after each ready.
  - Expect exactly one if_ready per transaction (no duplicate grant from the DONE cycle).
  - Expect successive mem_en pulses spaced 3+MEM_LAT cycles apart.
